// File: rtl/if_prefetch.sv
// -----------------------------------------------------------------------------
// if_prefetch -- instruction fetch / prefetch queue
//
// Issues sequential fetch requests to an in-order instruction memory, collects
// the returned words in a small FIFO and presents them to decode together with
// the PC of the following instruction (PC + 4).  A branch redirect flushes the
// queue, reloads the fetch PC and arranges for every response still in flight
// from the old stream to be dropped when it arrives.
//
// Optional build macro:
//   IF_BYPASS_EN  when defined, a kept response that arrives while the queue is
//                 empty is presented to decode in the same cycle; it is only
//                 written into the queue if decode does not take it.
//
// Parameters:
//   ADDR_WIDTH  request address width (low bits of the 32-bit PC)
//   DATA_WIDTH  instruction word width
//   DEPTH       prefetch queue entries (power of two, 2..16)
//   RESET_PC    fetch PC after reset
//
// Ports:
//   Clock        rising-edge clock
//   nReset       asynchronous active-low reset
//   BranchTaken  redirect + flush request
//   BranchAddr   redirect target PC
//   ReqValid     fetch request valid (combinational from counts)
//   ReqReady     memory accepts the request
//   InstrAddr    request address, straight from the PC register
//   RespValid    memory returns one word, in request order
//   InstrMem     returned word
//   OutValid     instruction available to decode
//   OutReady     decode accepts the instruction
//   InstrOut     head instruction word
//   PCAddrInc    PC of the head instruction plus 4
// -----------------------------------------------------------------------------
module if_prefetch #(
    parameter int          ADDR_WIDTH = 16,
    parameter int          DATA_WIDTH = 32,
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic                  BranchTaken,
    input  logic [31:0]           BranchAddr,
    output logic                  ReqValid,
    input  logic                  ReqReady,
    output logic [ADDR_WIDTH-1:0] InstrAddr,
    input  logic                  RespValid,
    input  logic [DATA_WIDTH-1:0] InstrMem,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [DATA_WIDTH-1:0] InstrOut,
    output logic [31:0]           PCAddrInc
);

    localparam int PW = $clog2(DEPTH);   // queue pointer width
    localparam int CW = PW + 1;          // counts 0..DEPTH
    localparam int SW = CW + 1;          // queue + outstanding sum
    localparam logic [SW-1:0] DEPTH_V = SW'(DEPTH);

    // Architectural state
    logic [31:0]           pc_r;         // next address to request
    logic [31:0]           resp_pc_r;    // PC of the oldest kept request still in flight
    logic [CW-1:0]         outst_r;      // requests issued but not yet answered
    logic [CW-1:0]         disc_r;       // in-flight responses still to be thrown away
    logic [CW-1:0]         cnt_r;        // queue occupancy
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [DATA_WIDTH-1:0] instr_mem_r [DEPTH];
    logic [31:0]           pcinc_mem_r [DEPTH];

    // Per-cycle decode
    logic          xfer_s;
    logic          resp_ok_s;
    logic          resp_keep_s;
    logic          head_valid_s;
    logic          bypass_s;
    logic          enq_s;
    logic          deq_s;
    logic [31:0]   resp_pcinc_s;
    logic [SW-1:0] occ_s;

    // Queue entries plus in-flight requests never exceed DEPTH, so the queue
    // always has room for every response that can come back.
    assign occ_s    = SW'(cnt_r) + SW'(outst_r);
    assign ReqValid = (occ_s < DEPTH_V) && !BranchTaken;
    assign xfer_s   = ReqValid && ReqReady;

    assign InstrAddr = pc_r[ADDR_WIDTH-1:0];

    // A response with nothing outstanding is illegal; ignoring it keeps the
    // counters from wrapping.
    assign resp_ok_s    = RespValid && (outst_r != {CW{1'b0}});
    assign resp_keep_s  = resp_ok_s && (disc_r == {CW{1'b0}}) && !BranchTaken;
    assign resp_pcinc_s = resp_pc_r + 32'd4;
    assign head_valid_s = (cnt_r != {CW{1'b0}});

`ifdef IF_BYPASS_EN
    assign bypass_s = resp_keep_s && !head_valid_s;
`else
    assign bypass_s = 1'b0;
`endif

    // A bypassed word taken by decode this cycle never enters the queue.
    assign enq_s = resp_keep_s && !(bypass_s && OutReady);
    assign deq_s = head_valid_s && OutReady && !BranchTaken;

    // Decode-side outputs: queue head, or the bypassed response when enabled.
    always_comb begin
        OutValid  = head_valid_s;
        InstrOut  = instr_mem_r[rd_ptr_r];
        PCAddrInc = pcinc_mem_r[rd_ptr_r];
`ifdef IF_BYPASS_EN
        if (bypass_s) begin
            OutValid  = 1'b1;
            InstrOut  = InstrMem;
            PCAddrInc = resp_pcinc_s;
        end else begin
            OutValid  = head_valid_s;
        end
`endif
    end

    // Fetch PC: redirect wins, otherwise step by one word per accepted request.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            pc_r <= RESET_PC;
        end else if (BranchTaken) begin
            pc_r <= BranchAddr;
        end else if (xfer_s) begin
            pc_r <= pc_r + 32'd4;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Response PC: requests are contiguous between redirects and answered in
    // order, so the PC of each kept response is one word past the previous.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            resp_pc_r <= RESET_PC;
        end else if (BranchTaken) begin
            resp_pc_r <= BranchAddr;
        end else if (resp_keep_s) begin
            resp_pc_r <= resp_pcinc_s;
        end else begin
            resp_pc_r <= resp_pc_r;
        end
    end

    // Outstanding request counter (no transfer can coincide with a redirect).
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            outst_r <= {CW{1'b0}};
        end else begin
            case ({xfer_s, resp_ok_s})
                2'b10:   outst_r <= outst_r + CW'(1'b1);
                2'b01:   outst_r <= outst_r - CW'(1'b1);
                default: outst_r <= outst_r;
            endcase
        end
    end

    // Discard counter: everything in flight at a redirect belongs to the old
    // stream; a response arriving in the redirect cycle is already dropped.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            disc_r <= {CW{1'b0}};
        end else if (BranchTaken) begin
            disc_r <= outst_r - CW'(resp_ok_s);
        end else if (resp_ok_s && (disc_r != {CW{1'b0}})) begin
            disc_r <= disc_r - CW'(1'b1);
        end else begin
            disc_r <= disc_r;
        end
    end

    // Queue occupancy and pointers; a redirect empties the queue.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            cnt_r    <= {CW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else if (BranchTaken) begin
            cnt_r    <= {CW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            cnt_r    <= cnt_r + CW'(enq_s) - CW'(deq_s);
            wr_ptr_r <= wr_ptr_r + PW'(enq_s);
            rd_ptr_r <= rd_ptr_r + PW'(deq_s);
        end
    end

    // Queue storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_r[i] <= {DATA_WIDTH{1'b0}};
                pcinc_mem_r[i] <= 32'h0;
            end
        end else if (enq_s) begin
            instr_mem_r[wr_ptr_r] <= InstrMem;
            pcinc_mem_r[wr_ptr_r] <= resp_pcinc_s;
        end else begin
            instr_mem_r[wr_ptr_r] <= instr_mem_r[wr_ptr_r];
            pcinc_mem_r[wr_ptr_r] <= pcinc_mem_r[wr_ptr_r];
        end
    end

    if_prefetch_chk #(
        .CW (CW),
        .AW (ADDR_WIDTH)
    ) u_chk (
        .clk         (Clock),
        .rst_n       (nReset),
        .branch      (BranchTaken),
        .resp_valid  (RespValid),
        .req_valid   (ReqValid),
        .req_ready   (ReqReady),
        .outstanding (outst_r),
        .req_addr    (InstrAddr)
    );

endmodule

// -----------------------------------------------------------------------------
// if_prefetch_chk -- protocol checks for if_prefetch
//
// Ports: clock/reset, branch, request handshake, response strobe, the
// outstanding request count and the request address.
// -----------------------------------------------------------------------------
module if_prefetch_chk #(
    parameter int CW = 3,
    parameter int AW = 16
) (
    input logic          clk,
    input logic          rst_n,
    input logic          branch,
    input logic          resp_valid,
    input logic          req_valid,
    input logic          req_ready,
    input logic [CW-1:0] outstanding,
    input logic [AW-1:0] req_addr
);

    // Memory may only answer a request that is actually in flight.
    a_resp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
        resp_valid |-> (outstanding != {CW{1'b0}}))
        else $error("if_prefetch: response with no outstanding request");

    // A stalled request stays up unless a redirect withdraws it.
    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (req_valid && !req_ready) |=> (req_valid || branch))
        else $error("if_prefetch: request dropped while stalled");

    // A stalled request keeps its address.
    a_addr_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (req_valid && !req_ready) |=> $stable(req_addr))
        else $error("if_prefetch: request address moved while stalled");

endmodule

// File: tb/tb_if_prefetch.sv
// -----------------------------------------------------------------------------
// tb_if_prefetch -- self-checking bench for if_prefetch
//
// A queue-based reference model (in-flight request list + instruction FIFO)
// is compared against the DUT on every falling clock edge; directed scenarios
// add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_if_prefetch;

    localparam int DEPTH = 4;
`ifdef IF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        nReset = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchAddr = 32'h0;
    logic        ReqReady = 1'b0;
    logic        RespValid = 1'b0;
    logic [31:0] InstrMem = 32'h0;
    logic        OutReady = 1'b0;
    logic        ReqValid;
    logic [15:0] InstrAddr;
    logic        OutValid;
    logic [31:0] InstrOut;
    logic [31:0] PCAddrInc;

    int checks = 0;
    int errors = 0;

    if_prefetch #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .Clock       (Clock),
        .nReset      (nReset),
        .BranchTaken (BranchTaken),
        .BranchAddr  (BranchAddr),
        .ReqValid    (ReqValid),
        .ReqReady    (ReqReady),
        .InstrAddr   (InstrAddr),
        .RespValid   (RespValid),
        .InstrMem    (InstrMem),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .InstrOut    (InstrOut),
        .PCAddrInc   (PCAddrInc)
    );

    always #5 Clock = ~Clock;

    typedef struct packed { logic [31:0] pc; logic disc; } infl_t;
    typedef struct packed { logic [31:0] instr; logic [31:0] pcinc; } ent_t;

    infl_t       infl_q[$];   // requests in flight, oldest first
    ent_t        oq[$];       // instructions waiting for decode
    logic [31:0] m_pc = 32'h0;

    // Memory contents: a recognisable word derived from its address.
    function automatic logic [31:0] word(input logic [31:0] pc);
        return {pc[15:0] ^ 16'hA5A5, pc[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Model + compare: outputs from the model's current state and inputs,
    // then advance the model to its state after the next rising edge.
    always @(negedge Clock) begin : cmp
        logic        e_rv;
        logic        e_ov;
        logic        byp;
        logic [31:0] e_instr;
        logic [31:0] e_pcinc;
        infl_t       f;
        ent_t        e;
        if (!nReset) begin
            infl_q.delete();
            oq.delete();
            m_pc = 32'h0;
        end else begin
            byp     = 1'b0;
            e_rv    = ((oq.size() + infl_q.size()) < DEPTH) && !BranchTaken;
            e_ov    = (oq.size() != 0);
            e_instr = 32'h0;
            e_pcinc = 32'h0;
            if (e_ov) begin
                e_instr = oq[0].instr;
                e_pcinc = oq[0].pcinc;
            end else if (BYP && RespValid && !BranchTaken && infl_q.size() != 0 && !infl_q[0].disc) begin
                byp     = 1'b1;
                e_ov    = 1'b1;
                e_instr = InstrMem;
                e_pcinc = infl_q[0].pc + 32'd4;
            end
            check("ReqValid", {31'h0, ReqValid}, {31'h0, e_rv});
            check("InstrAddr", {16'h0, InstrAddr}, {16'h0, m_pc[15:0]});
            check("OutValid", {31'h0, OutValid}, {31'h0, e_ov});
            if (e_ov) begin
                check("InstrOut", InstrOut, e_instr);
                check("PCAddrInc", PCAddrInc, e_pcinc);
            end
            if (BranchTaken) begin
                if (RespValid && infl_q.size() != 0) void'(infl_q.pop_front());
                foreach (infl_q[i]) infl_q[i].disc = 1'b1;
                oq.delete();
                m_pc = BranchAddr;
            end else begin
                if (e_ov && OutReady && !byp) void'(oq.pop_front());
                if (RespValid && infl_q.size() != 0) begin
                    f = infl_q.pop_front();
                    if (!f.disc && !(byp && OutReady)) begin
                        e.instr = InstrMem;
                        e.pcinc = f.pc + 32'd4;
                        oq.push_back(e);
                    end
                end
                if (e_rv && ReqReady) begin
                    f.pc   = m_pc;
                    f.disc = 1'b0;
                    infl_q.push_back(f);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // Drive one cycle of inputs; the memory answers the oldest in-flight request.
    task automatic set_in(input logic bt, input logic [31:0] ba, input logic rr,
                          input logic rv, input logic ordy);
        BranchTaken = bt;
        BranchAddr  = ba;
        ReqReady    = rr;
        OutReady    = ordy;
        if (rv && infl_q.size() != 0) begin
            RespValid = 1'b1;
            InstrMem  = word(infl_q[0].pc);
        end else begin
            RespValid = 1'b0;
            InstrMem  = 32'h0;
        end
    endtask

    task automatic adv();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        nReset = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        nReset = 1'b1;
        #1;
        check("rst_reqvalid", {31'h0, ReqValid}, 32'h1);
        check("rst_instraddr", {16'h0, InstrAddr}, 32'h0);
        check("rst_outvalid", {31'h0, OutValid}, 32'h0);
        check("rst_instrout", InstrOut, 32'h0);
        check("rst_pcaddrinc", PCAddrInc, 32'h0);
    endtask

    int nx;

    initial begin
        do_reset();

        // Streaming: one request per cycle, answered the next cycle.
        for (int k = 0; k < 12; k++) begin
            set_in(1'b0, 32'h0, 1'b1, (k >= 1), 1'b1);
            #2;
            check("stream_addr", {16'h0, InstrAddr}, 32'(4 * k));
            if (k == 1) check("fill_ov", {31'h0, OutValid}, {31'h0, BYP});
            if (k >= 2) begin
                check("stream_ov", {31'h0, OutValid}, 32'h1);
                check("stream_pcinc", PCAddrInc, 32'(4 * (k - 1)) + (BYP ? 32'd4 : 32'd0));
            end
            if (k == 2) check("first_instr", InstrOut, BYP ? 32'hA5A10004 : 32'hA5A50000);
            adv();
        end
        repeat (3) begin
            set_in(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
            adv();
        end

        // Decode stalled: queue fills to DEPTH, then one slot frees up.
        do_reset();
        nx = 0;
        for (int k = 0; k < 8; k++) begin
            set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
            #2;
            if (ReqValid && ReqReady) nx++;
            adv();
        end
        check("full_xfers", 32'(nx), 32'd4);
        set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        #2;
        check("full_reqvalid", {31'h0, ReqValid}, 32'h0);
        check("full_outvalid", {31'h0, OutValid}, 32'h1);
        adv();
        set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        #2;
        if (ReqValid && ReqReady) nx++;
        adv();
        for (int k = 0; k < 4; k++) begin
            set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
            #2;
            if (ReqValid && ReqReady) nx++;
            adv();
        end
        check("one_more_xfer", 32'(nx), 32'd5);

        // Redirect with two requests in flight.
        do_reset();
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b1); adv();
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b1); adv();
        set_in(1'b1, 32'h100, 1'b1, 1'b0, 1'b1);
        #2;
        check("br_reqvalid", {31'h0, ReqValid}, 32'h0);
        adv();
        set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        #2;
        check("flush_ov", {31'h0, OutValid}, 32'h0);
        check("flush_addr", {16'h0, InstrAddr}, 32'h100);
        check("flush_reqvalid", {31'h0, ReqValid}, 32'h1);
        adv();
        set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        #2;
        check("drop_ov", {31'h0, OutValid}, 32'h0);
        adv();
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 1'b0); adv();
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        #2;
        check("br_ov", {31'h0, OutValid}, 32'h1);
        check("br_pcinc", PCAddrInc, 32'h104);
        check("br_instr", InstrOut, 32'hA4A50100);
        adv();
        repeat (4) begin
            set_in(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
            adv();
        end

        // Redirect coincident with a response and with decode ready.
        do_reset();
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); adv();
        set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b0); adv();
        set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b0); adv();
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); adv();
        set_in(1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
        #2;
        check("brx_ov_before", {31'h0, OutValid}, 32'h1);
        check("brx_reqvalid", {31'h0, ReqValid}, 32'h0);
        adv();
        set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        #2;
        check("brx_ov_after", {31'h0, OutValid}, 32'h0);
        check("brx_addr", {16'h0, InstrAddr}, 32'h200);
        adv();
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        #2;
        check("brx_disc_ov", {31'h0, OutValid}, {31'h0, BYP});
        adv();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        check("brx_new_ov", {31'h0, OutValid}, 32'h1);
        check("brx_pcinc", PCAddrInc, 32'h204);
        check("brx_instr", InstrOut, 32'hA7A50200);
        adv();
        repeat (2) begin
            set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            adv();
        end

        // PC wraps past the top of the address space.
        do_reset();
        set_in(1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0); adv();
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        #2;
        check("wrap_addr_top", {16'h0, InstrAddr}, 32'hFFFC);
        adv();
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        #2;
        check("wrap_addr_zero", {16'h0, InstrAddr}, 32'h0);
        adv();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        check("wrap_ov", {31'h0, OutValid}, 32'h1);
        check("wrap_pcinc", PCAddrInc, 32'h0);
        adv();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1); adv();

`ifdef IF_BYPASS_EN
        // Same-cycle bypass into an empty queue.
        do_reset();
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b1); adv();
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        InstrMem = 32'hDEADBEEF;
        #2;
        check("byp_ov", {31'h0, OutValid}, 32'h1);
        check("byp_instr", InstrOut, 32'hDEADBEEF);
        adv();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        #2;
        check("byp_queue_empty", {31'h0, OutValid}, 32'h0);
        adv();
`endif

        // Reset while requests are in flight.
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b1); adv();
        set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        #3;
        nReset = 1'b0;
        #1;
        check("midrst_outvalid", {31'h0, OutValid}, 32'h0);
        check("midrst_addr", {16'h0, InstrAddr}, 32'h0);
        do_reset();
        repeat (3) begin
            set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
